wm_ctrl_param: RTL and testbench
================================

Name: wm_ctrl_param

Overview:
- Parametrised washing-machine sequencer; next generation of the single-program washing_machine FSM.
- Runs FILL → WASH → DRAIN → RINSE×N → SPIN with per-phase cycle counts set by parameters.
- Adds four wash modes, a programmable rinse count, abort-with-safe-drain, and actuator/door-lock outputs.
- Sits between the front-panel input logic and the actuator drivers.

Parameters:
- CNT_W, 8, width of the phase cycle counter.
- FILL_CYC, 4, cycles spent in FILL.
- WASH_CYC, 8, base cycles in WASH. Constraint: 2*WASH_CYC <= 2^CNT_W.
- DRAIN_CYC, 3, cycles in DRAIN.
- RINSE_CYC, 5, cycles per rinse pass.
- SPIN_CYC, 6, cycles in SPIN.
- N_RINSE, 2, rinse passes in normal mode. Range 1..6.

Ports:
- clk  in  1  clock; all flops rising-edge.
- res  in  1  reset, asynchronous, active-low.
- start  in  1  level; sampled only in IDLE.
- pause  in  1  level; freezes the sequence while high.
- abort  in  1  level; requests a safe stop.
- mode  in  2  0 normal, 1 quick, 2 heavy, 3 rinse_spin; latched on start.
- phase  out  3  IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6.
- count  out  CNT_W  cycle index within the current phase.
- busy  out  1  high when phase is not IDLE and not DONE.
- door_lock  out  1  equals busy.
- valve  out  1  FILL or RINSE, and not frozen.
- motor  out  1  WASH, RINSE or SPIN, and not frozen.
- pump  out  1  DRAIN or SPIN, and not frozen.
- done  out  1  one-cycle pulse; phase == DONE.
- aborted  out  1  one-cycle pulse after an abort drain completes.

Behaviour:
- Reset (res=0, async): phase=IDLE, count=0, rinse index=0, mode latch=0, abort flag=0. All outputs 0.
- Reset mid-cycle forces IDLE immediately; no drain is performed.
- Start: in IDLE, start=1 at an edge latches mode and sets count=0.
  - Next phase is FILL, or RINSE when mode=3.
  - start is ignored in every other phase.
- Phase durations:
  - count increments each unfrozen cycle.
  - At count == dur-1, the next edge advances the phase and clears count.
- Wash duration and rinse passes by mode:
  - mode 0: WASH_CYC, N_RINSE passes.
  - mode 1: max(WASH_CYC>>1, 1), 1 pass.
  - mode 2: 2*WASH_CYC (computed in CNT_W bits), N_RINSE+1 passes.
  - mode 3: FILL/WASH/DRAIN skipped, 1 pass.
- RINSE loop: rinse index counts passes. RINSE → RINSE (count cleared) until the last pass, then RINSE → SPIN.
- SPIN → DONE. DONE lasts exactly one cycle, then IDLE.
- Pause (frozen = pause && busy && !abort flag):
  - Phase, count and rinse index hold.
  - valve, motor and pump are forced to 0; door_lock stays 1.
  - Pause in IDLE or DONE has no effect.
  - Deassertion resumes at the held count with no lost or extra cycles.
- Abort: abort=1 at an edge while busy and abort flag=0:
  - sets the abort flag; next phase is DRAIN with count=0.
  - This applies even from DRAIN, which restarts its count.
  - The abort drain ignores pause and runs DRAIN_CYC cycles.
  - It then goes to IDLE with aborted=1 for one cycle; done never asserts; the flag clears.
- Abort priority:
  - abort and pause in the same cycle: abort wins.
  - Further abort during the abort drain: ignored.
  - Abort in IDLE or DONE: ignored.
- start asserted on the DONE cycle: ignored. A new run needs start while in IDLE.

Test Plan:
- Defaults, mode=0, start pulsed 1 cycle → phases 1,2,3,4,4,5,6 with lengths 4,8,3,5,5,6. done pulses exactly 31 edges after the start-sampling edge.
- mode=1 → done at 22 edges; mode=2 → done at 44 edges (WASH count reaches 15, three rinse passes); mode=3 → phase goes IDLE→RINSE, done at 11 edges.
- mode=0, pause high for 5 cycles starting at WASH count=3 → count holds at 3, motor=0, door_lock=1. done arrives at 36 edges.
- Abort asserted at RINSE pass 2, count=2, with pause also high → DRAIN for 3 cycles with pump=1. Then IDLE, aborted=1 for one cycle, done stays 0.
- res driven low asynchronously mid-SPIN (between edges) → all outputs 0 immediately. After release, start with mode=1 gives the normal 22-edge run.
- start held high through the whole run → no retrigger until IDLE. The second run's FILL begins on the edge after the DONE cycle.

Source files
------------

// File: rtl/wm_ctrl_param.sv
// rtl/wm_ctrl_param.sv - parametrised washing-machine sequencer with modes, rinse loop, pause and abort-drain
module wm_ctrl_param #(
  parameter int CNT_W     = 8,
  parameter int FILL_CYC  = 4,
  parameter int WASH_CYC  = 8,
  parameter int DRAIN_CYC = 3,
  parameter int RINSE_CYC = 5,
  parameter int SPIN_CYC  = 6,
  parameter int N_RINSE   = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [1:0]       mode,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             door_lock,
  output logic             valve,
  output logic             motor,
  output logic             pump,
  output logic             done,
  output logic             aborted
);

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_FILL  = 3'd1;
  localparam logic [2:0] P_WASH  = 3'd2;
  localparam logic [2:0] P_DRAIN = 3'd3;
  localparam logic [2:0] P_RINSE = 3'd4;
  localparam logic [2:0] P_SPIN  = 3'd5;
  localparam logic [2:0] P_DONE  = 3'd6;

  localparam int WASH_Q = ((WASH_CYC >> 1) > 0) ? (WASH_CYC >> 1) : 1;

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_LAST    = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST   = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST    = CNT_W'(SPIN_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LAST_N  = CNT_W'(WASH_CYC - 1);
  localparam logic [CNT_W-1:0] WASH_LAST_Q  = CNT_W'(WASH_Q - 1);
  // Heavy wash length wraps in CNT_W bits; 2^CNT_W cycles then ends at all-ones.
  localparam logic [CNT_W-1:0] WASH_DUR_H   = CNT_W'(2 * WASH_CYC);
  localparam logic [CNT_W-1:0] WASH_LAST_H  = WASH_DUR_H - ONE;
  localparam logic [2:0]       RPASS_LAST_N = 3'(N_RINSE - 1);
  localparam logic [2:0]       RPASS_LAST_H = 3'(N_RINSE);

  logic [1:0]       mode_q;
  logic [2:0]       rinse_q;
  logic             abort_q;
  logic             frozen;
  logic [CNT_W-1:0] wash_last;
  logic [2:0]       rpass_last;
  logic [CNT_W-1:0] phase_last;
  logic             at_end;

  assign busy      = (phase != P_IDLE) && (phase != P_DONE);
  assign door_lock = busy;
  assign frozen    = pause && busy && !abort_q;
  assign valve     = ((phase == P_FILL) || (phase == P_RINSE)) && !frozen;
  assign motor     = ((phase == P_WASH) || (phase == P_RINSE) || (phase == P_SPIN)) && !frozen;
  assign pump      = ((phase == P_DRAIN) || (phase == P_SPIN)) && !frozen;
  assign done      = (phase == P_DONE);

  always_comb begin
    wash_last  = WASH_LAST_N;
    rpass_last = RPASS_LAST_N;
    case (mode_q)
      2'd1: begin wash_last = WASH_LAST_Q; rpass_last = 3'd0;         end
      2'd2: begin wash_last = WASH_LAST_H; rpass_last = RPASS_LAST_H; end
      2'd3: begin wash_last = WASH_LAST_N; rpass_last = 3'd0;         end
      default: begin wash_last = WASH_LAST_N; rpass_last = RPASS_LAST_N; end
    endcase
  end

  always_comb begin
    phase_last = '0;
    case (phase)
      P_FILL:  phase_last = FILL_LAST;
      P_WASH:  phase_last = wash_last;
      P_DRAIN: phase_last = DRAIN_LAST;
      P_RINSE: phase_last = RINSE_LAST;
      P_SPIN:  phase_last = SPIN_LAST;
      default: phase_last = '0;
    endcase
  end

  assign at_end = (count == phase_last);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      phase   <= P_IDLE;
      count   <= '0;
      rinse_q <= 3'd0;
      mode_q  <= 2'd0;
      abort_q <= 1'b0;
      aborted <= 1'b0;
    end else begin
      aborted <= 1'b0;
      case (phase)
        P_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            count   <= '0;
            rinse_q <= 3'd0;
            phase   <= (mode == 2'd3) ? P_RINSE : P_FILL;
          end
        end
        P_DONE: phase <= P_IDLE;
        default: begin
          // Abort outranks pause; a second abort during the safe drain is ignored.
          if (abort && !abort_q) begin
            abort_q <= 1'b1;
            phase   <= P_DRAIN;
            count   <= '0;
          end else if (!frozen) begin
            if (!at_end) begin
              count <= count + ONE;
            end else begin
              count <= '0;
              case (phase)
                P_FILL: phase <= P_WASH;
                P_WASH: phase <= P_DRAIN;
                P_DRAIN: begin
                  if (abort_q) begin
                    phase   <= P_IDLE;
                    abort_q <= 1'b0;
                    aborted <= 1'b1;
                  end else begin
                    phase <= P_RINSE;
                  end
                end
                P_RINSE: begin
                  if (rinse_q == rpass_last) phase <= P_SPIN;
                  else rinse_q <= rinse_q + 3'd1;
                end
                P_SPIN:  phase <= P_DONE;
                default: phase <= P_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm_ctrl_param.sv
// tb/tb_wm_ctrl_param.sv - directed and randomized checks of wm_ctrl_param against a schedule-queue model
module tb_wm_ctrl_param;

  localparam int CNT_W     = 8;
  localparam int FILL_CYC  = 4;
  localparam int WASH_CYC  = 8;
  localparam int DRAIN_CYC = 3;
  localparam int RINSE_CYC = 5;
  localparam int SPIN_CYC  = 6;
  localparam int N_RINSE   = 2;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic             pause;
  logic             abort;
  logic [1:0]       mode;
  logic [2:0]       phase;
  logic [CNT_W-1:0] count;
  logic             busy, door_lock, valve, motor, pump, done, aborted;

  int n_checks = 0;
  int n_pass   = 0;

  wm_ctrl_param #(
    .CNT_W(CNT_W), .FILL_CYC(FILL_CYC), .WASH_CYC(WASH_CYC), .DRAIN_CYC(DRAIN_CYC),
    .RINSE_CYC(RINSE_CYC), .SPIN_CYC(SPIN_CYC), .N_RINSE(N_RINSE)
  ) dut (
    .clk(clk), .res(res), .start(start), .pause(pause), .abort(abort), .mode(mode),
    .phase(phase), .count(count), .busy(busy), .door_lock(door_lock), .valve(valve),
    .motor(motor), .pump(pump), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: current (phase,count) plus a queue of every step still to come in the run.
  int m_ph, m_ct;
  bit m_abort, m_aborted;
  int q_ph[$];
  int q_ct[$];

  task automatic push_seg(input int ph, input int len);
    for (int i = 0; i < len; i++) begin
      q_ph.push_back(ph);
      q_ct.push_back(i);
    end
  endtask

  task automatic pop_cur();
    m_ph = q_ph.pop_front();
    m_ct = q_ct.pop_front();
  endtask

  task automatic build_run(input int md);
    int wd, np;
    wd = WASH_CYC;
    np = N_RINSE;
    if (md == 1) begin
      wd = ((WASH_CYC / 2) > 0) ? (WASH_CYC / 2) : 1;
      np = 1;
    end else if (md == 2) begin
      wd = (2 * WASH_CYC) % (1 << CNT_W);
      if (wd == 0) wd = 1 << CNT_W;
      np = N_RINSE + 1;
    end else if (md == 3) begin
      np = 1;
    end
    q_ph.delete();
    q_ct.delete();
    if (md != 3) begin
      push_seg(1, FILL_CYC);
      push_seg(2, wd);
      push_seg(3, DRAIN_CYC);
    end
    for (int p = 0; p < np; p++) push_seg(4, RINSE_CYC);
    push_seg(5, SPIN_CYC);
    push_seg(6, 1);
  endtask

  task automatic model_reset();
    m_ph = 0; m_ct = 0; m_abort = 0; m_aborted = 0;
    q_ph.delete();
    q_ct.delete();
  endtask

  task automatic model_step(input bit st, input bit pa, input bit ab, input int md);
    m_aborted = 0;
    if (m_ph == 0) begin
      if (st) begin
        build_run(md);
        pop_cur();
      end
    end else if (m_ph == 6) begin
      m_ph = 0; m_ct = 0;
    end else if (ab && !m_abort) begin
      m_abort = 1;
      q_ph.delete();
      q_ct.delete();
      for (int i = 1; i < DRAIN_CYC; i++) begin
        q_ph.push_back(3);
        q_ct.push_back(i);
      end
      m_ph = 3; m_ct = 0;
    end else if (pa && !m_abort) begin
      // frozen: nothing moves
    end else if (q_ph.size() == 0) begin
      m_ph = 0; m_ct = 0; m_abort = 0; m_aborted = 1;
    end else begin
      pop_cur();
    end
  endtask

  task automatic check_model();
    bit e_busy, e_frz;
    e_busy = (m_ph != 0) && (m_ph != 6);
    e_frz  = pause && e_busy && !m_abort;
    check("phase", int'(phase), m_ph);
    check("count", int'(count), m_ct);
    check("busy", int'(busy), int'(e_busy));
    check("door_lock", int'(door_lock), int'(e_busy));
    check("valve", int'(valve), int'((m_ph == 1 || m_ph == 4) && !e_frz));
    check("motor", int'(motor), int'((m_ph == 2 || m_ph == 4 || m_ph == 5) && !e_frz));
    check("pump", int'(pump), int'((m_ph == 3 || m_ph == 5) && !e_frz));
    check("done", int'(done), int'(m_ph == 6));
    check("aborted", int'(aborted), int'(m_aborted));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_outs"}, int'({busy, door_lock, valve, motor, pump, done, aborted}), 0);
  endtask

  task automatic run_check(input logic [1:0] md, input int exp_edges, input int exp_wmax,
                           input bit do_pause, input bit hold_start, input string tag);
    int e, pc, wmax;
    bit seen;
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    check({tag, "_first_phase"}, int'(phase), (md == 2'd3) ? 4 : 1);
    e = 0; pc = 0; wmax = 0; seen = 0;
    while (!done && e < 300) begin
      if (phase == 3'd2 && int'(count) > wmax) wmax = int'(count);
      if (pc > 0) begin
        check({tag, "_pause_count"}, int'(count), 3);
        check({tag, "_pause_motor"}, int'(motor), 0);
        check({tag, "_pause_lock"}, int'(door_lock), 1);
        pc--;
        if (pc == 0) pause = 1'b0;
      end else if (do_pause && !seen && phase == 3'd2 && count == 3) begin
        pause = 1'b1;
        pc = 5;
        seen = 1;
      end
      tick();
      e++;
    end
    check({tag, "_done_edges"}, e, exp_edges);
    check({tag, "_wash_max"}, wmax, exp_wmax);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    if (hold_start) begin
      check({tag, "_idle_after_done"}, int'(phase), 0);
      tick();
      check({tag, "_retrigger_fill"}, int'(phase), 1);
      start = 1'b0;
    end
  endtask

  initial begin
    res = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; mode = 2'd0;
    #2;
    check_all_zero("reset");
    tick();
    check_all_zero("reset_hold");
    res = 1'b1;

    run_check(2'd0, 31, 7, 0, 0, "normal");
    run_check(2'd1, 22, 3, 0, 0, "quick");
    run_check(2'd2, 44, 15, 0, 0, "heavy");
    run_check(2'd3, 11, 0, 0, 0, "rinse_spin");
    run_check(2'd0, 36, 7, 1, 0, "paused");

    // Abort during rinse pass 2 with pause also high.
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (22) tick();
    check("abort_pre_phase", int'(phase), 4);
    check("abort_pre_count", int'(count), 2);
    abort = 1'b1; pause = 1'b1;
    for (int i = 0; i < DRAIN_CYC; i++) begin
      tick();
      check("abort_drain_phase", int'(phase), 3);
      check("abort_drain_count", int'(count), i);
      check("abort_drain_pump", int'(pump), 1);
      check("abort_drain_done", int'(done), 0);
    end
    tick();
    check("abort_idle", int'(phase), 0);
    check("abort_pulse", int'(aborted), 1);
    check("abort_no_done", int'(done), 0);
    tick();
    check("abort_pulse_end", int'(aborted), 0);
    check("abort_in_idle", int'(phase), 0);
    abort = 1'b0; pause = 1'b0;

    // Asynchronous reset mid-SPIN.
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (27) tick();
    check("spin_before_reset", int'(phase), 5);
    #2 res = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    res = 1'b1;
    run_check(2'd1, 22, 3, 0, 0, "after_reset");

    run_check(2'd0, 31, 7, 0, 1, "held_start");

    @(negedge clk);
    res = 1'b0;
    tick();
    res = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit st, pa, ab;
      int md;
      check_model();
      st = ($urandom_range(0, 9) < 3);
      pa = ($urandom_range(0, 99) < 12);
      ab = ($urandom_range(0, 199) < 3);
      md = $urandom_range(0, 3);
      start = st; pause = pa; abort = ab; mode = 2'(md);
      model_step(st, pa, ab, md);
      tick();
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
